// File: rtl/decryptor_pkg.sv
// -----------------------------------------------------------------------------
// decryptor_pkg
// Shared types and GF(2^8) helpers for the AES inverse cipher.
//   dec_state_t      one-hot FSM encoding (IDLE / SBOX / EXOR)
//   NR_128/192/256   round counts for the three key sizes
//   xtime, gf_mul    field arithmetic, reduction polynomial 0x11B
//   gmul9/11/13/14   InvMixColumns coefficients built from xtime chains
//   inv_sbox_fn      InvSubBytes for one byte
//   inv_shift_rows   InvShiftRows for the full 128-bit state
//   inv_mix_columns  InvMixColumns for the full 128-bit state
// State layout: byte k of the block sits at bits [127-8k -: 8], so byte 0 is
// the MSB byte; byte k is row k%4, column k/4.
// -----------------------------------------------------------------------------
package decryptor_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    SBOX = 3'b010,
    EXOR = 3'b100
  } dec_state_t;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Inverse affine transform followed by the multiplicative inverse.
  // The inverse is x^254 = x^2 * x^4 * ... * x^128, which also maps 0 to 0.
  function automatic logic [7:0] inv_sbox_fn(input logic [7:0] b);
    logic [7:0] t, sq, r;
    for (int i = 0; i < 8; i++)
      t[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
    t  = t ^ 8'h05;
    sq = t;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Row r is rotated right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + 4 - r) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 32] = {
        gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
        gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
        gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
        gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)
      };
    end
    return o;
  endfunction

endpackage

// File: rtl/decryptor_if.sv
// -----------------------------------------------------------------------------
// decryptor_if
// Data/control bundle between a key-schedule/host side (master) and the
// decryptor core (slave).
//   ciphertext   128  block to decrypt, byte 0 in bits 127:120
//   roundkey     128  K[Nr - round_count] from the external key schedule
//   start_dec    1    start request, honoured only while the core is idle
//   keylength*   1    key-size select, priority 128 > 192 > 256, none = 128
//   plaintext    128  result / working state register
//   plaintext_dv 1    one-cycle pulse when plaintext holds the result
//   round_count  4    rounds completed, 0..Nr
//   busy_dec     1    core is (or is about to be) processing
// -----------------------------------------------------------------------------
interface decryptor_if;
  logic [127:0] ciphertext;
  logic [127:0] roundkey;
  logic         start_dec;
  logic         keylength128;
  logic         keylength192;
  logic         keylength256;
  logic [127:0] plaintext;
  logic         plaintext_dv;
  logic [3:0]   round_count;
  logic         busy_dec;

  modport master (
    output ciphertext, roundkey, start_dec, keylength128, keylength192, keylength256,
    input  plaintext, plaintext_dv, round_count, busy_dec
  );

  modport slave (
    input  ciphertext, roundkey, start_dec, keylength128, keylength192, keylength256,
    output plaintext, plaintext_dv, round_count, busy_dec
  );
endinterface

// File: rtl/decryptor_inv_sbox.sv
// -----------------------------------------------------------------------------
// inv_sbox
// Registered inverse S-box for one byte; the register loads only when en = 1.
//   mclk  in   clock
//   en    in   load enable
//   in    in   8-bit input byte
//   out   out  8-bit registered InvSubBytes result
// No reset: the contents are always reloaded before they are consumed.
// -----------------------------------------------------------------------------
module inv_sbox
  import decryptor_pkg::*;
(
  input  logic       mclk,
  input  logic       en,
  input  logic [7:0] in,
  output logic [7:0] out
);

  always_ff @(posedge mclk) begin
    if (en) out <= inv_sbox_fn(in);
  end

endmodule

// File: rtl/decryptor.sv
// -----------------------------------------------------------------------------
// decryptor
// Iterative AES inverse cipher for 128/192/256-bit keys, one round per two
// clocks. The external key schedule supplies K[Nr - round_count].
//   mclk    in   single clock
//   arst_n  in   asynchronous reset, active low
//   bus     slave side of decryptor_if (see decryptor_if.sv for signals)
// Sequence: IDLE --start--> SBOX -> EXOR -> SBOX ... EXOR(last) -> IDLE.
// SBOX loads the inv_sbox registers; EXOR adds the round key and, except in
// the last round, applies InvMixColumns. The key is not read during SBOX,
// which gives a registered key schedule that cycle to advance.
// -----------------------------------------------------------------------------
module decryptor
  import decryptor_pkg::*;
(
  input  logic        mclk,
  input  logic        arst_n,
  decryptor_if.slave  bus
);

  dec_state_t   state;
  logic [127:0] state_reg;
  logic [127:0] shifted;
  logic [127:0] isb;
  logic [127:0] round_in;
  logic [3:0]   nr;
  logic [3:0]   nr_sel;
  logic [3:0]   round_count;
  logic         dv;
  logic         sbox_en;

  assign shifted  = inv_shift_rows(state_reg);
  assign round_in = isb ^ bus.roundkey;
  assign sbox_en  = (state == SBOX);

  // Key size priority: 128 wins over 192, which wins over 256; nothing set = 128.
  always_comb begin
    nr_sel = NR_128;
    if (bus.keylength128)      nr_sel = NR_128;
    else if (bus.keylength192) nr_sel = NR_192;
    else if (bus.keylength256) nr_sel = NR_256;
  end

  for (genvar i = 0; i < 16; i++) begin : g_isb
    inv_sbox u_inv_sbox (
      .mclk (mclk),
      .en   (sbox_en),
      .in   (shifted[127 - 8 * i -: 8]),
      .out  (isb[127 - 8 * i -: 8])
    );
  end

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      state_reg   <= '0;
      round_count <= '0;
      nr          <= NR_128;
      dv          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dv <= 1'b0;
          if (bus.start_dec) begin
            state_reg   <= bus.ciphertext ^ bus.roundkey;
            round_count <= 4'd1;
            nr          <= nr_sel;
            state       <= SBOX;
          end
        end
        SBOX: state <= EXOR;
        EXOR: begin
          if (round_count != nr) begin
            state_reg   <= inv_mix_columns(round_in);
            round_count <= round_count + 4'd1;
            state       <= SBOX;
          end else begin
            state_reg   <= round_in;
            round_count <= 4'd0;
            dv          <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The working state doubles as the result register, so a back-to-back start
  // immediately shows the new initial state on plaintext.
  assign bus.plaintext    = state_reg;
  assign bus.plaintext_dv = dv;
  assign bus.round_count  = round_count;
  assign bus.busy_dec     = ((state == IDLE) && bus.start_dec) || (state == SBOX) || (state == EXOR);

endmodule
